// File: rtl/fu_alg_sticky_acc.sv
// Alignment-shifter sticky reducer: ORs the shifted-out operand into one leading
// group plus NGRP equal groups and accumulates them across multi-beat operations.
module fu_alg_sticky_acc #(
    parameter int DATA_W = 68,
    parameter int LEAD_W = 4,
    parameter int GRP_W  = 16,
    parameter int LAT    = 1,
    localparam int NGRP  = (DATA_W - LEAD_W) / GRP_W
) (
    input  logic              nclk,
    input  logic              rst_b,
    input  logic              in_vld,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [0:DATA_W-1] in_data,
    input  logic              flush,
    output logic              out_vld,
    output logic [0:NGRP]     out_sticky,
    output logic              out_any,
    output logic              busy
);

    if (((DATA_W - LEAD_W) % GRP_W != 0) || (LAT != 1 && LAT != 2)) begin : g_param_chk
        $error("fu_alg_sticky_acc: groups must tile DATA_W-LEAD_W and LAT must be 1 or 2");
    end

    logic [0:NGRP] w_g;

    assign w_g[0] = |in_data[0:LEAD_W-1];
    for (genvar k = 1; k <= NGRP; k++) begin : g_grp
        assign w_g[k] = |in_data[LEAD_W+(k-1)*GRP_W +: GRP_W];
    end

    // Beat as seen by the accumulator; flush kills it in the same cycle.
    logic          w_a_vld;
    logic          w_a_first;
    logic          w_a_last;
    logic [0:NGRP] w_a_g;

    if (LAT == 2) begin : g_s1
        logic          r_s1_vld;
        logic          r_s1_first;
        logic          r_s1_last;
        logic [0:NGRP] r_s1_g;

        always_ff @(posedge nclk or negedge rst_b) begin
            if (!rst_b) begin
                r_s1_vld   <= 1'b0;
                r_s1_first <= 1'b0;
                r_s1_last  <= 1'b0;
                r_s1_g     <= '0;
            end else begin
                r_s1_vld <= in_vld & ~flush;
                if (in_vld) begin
                    r_s1_first <= in_first;
                    r_s1_last  <= in_last;
                    r_s1_g     <= w_g;
                end
            end
        end

        assign w_a_vld   = r_s1_vld & ~flush;
        assign w_a_first = r_s1_first;
        assign w_a_last  = r_s1_last;
        assign w_a_g     = r_s1_g;
    end else begin : g_s0
        assign w_a_vld   = in_vld & ~flush;
        assign w_a_first = in_first;
        assign w_a_last  = in_last;
        assign w_a_g     = w_g;
    end

    logic          r_busy;
    logic [0:NGRP] r_acc;
    logic          r_out_vld;
    logic [0:NGRP] r_sticky;
    logic          r_any;
    logic [0:NGRP] w_base;
    logic [0:NGRP] w_new;

    // A beat without an open operation starts one, with or without first.
    assign w_base = (w_a_first || !r_busy) ? '0 : r_acc;
    assign w_new  = w_base | w_a_g;

    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            r_busy    <= 1'b0;
            r_acc     <= '0;
            r_out_vld <= 1'b0;
            r_sticky  <= '0;
            r_any     <= 1'b0;
        end else begin
            r_out_vld <= 1'b0;
            if (flush) begin
                r_acc  <= '0;
                r_busy <= 1'b0;
            end else if (w_a_vld) begin
                r_acc  <= w_new;
                r_busy <= ~w_a_last;
                if (w_a_last) begin
                    r_out_vld <= 1'b1;
                    r_sticky  <= w_new;
                    r_any     <= |w_new;
                end
            end
        end
    end

    assign out_vld    = r_out_vld;
    assign out_sticky = r_sticky;
    assign out_any    = r_any;
    assign busy       = r_busy;

endmodule

// File: tb/tb_fu_alg_sticky_acc.sv
// Scoreboard bench: LAT=1 and LAT=2 instances share stimulus; a per-cycle
// reference model pushes expected results that a separate monitor pops.
module tb_fu_alg_sticky_acc;

    localparam int MAXC = 1024;

    typedef struct {
        logic [0:4] st;
        int         tag;
    } exp_t;

    logic        nclk = 1'b0;
    logic        rst_b;
    logic        in_vld, in_first, in_last, flush;
    logic [0:67] in_data;
    logic        o_vld1, o_any1, o_busy1;
    logic [0:4]  o_st1;
    logic        o_vld2, o_any2, o_busy2;
    logic [0:4]  o_st2;

    fu_alg_sticky_acc #(.LAT(1)) u_dut1 (
        .nclk(nclk), .rst_b(rst_b), .in_vld(in_vld), .in_first(in_first),
        .in_last(in_last), .in_data(in_data), .flush(flush),
        .out_vld(o_vld1), .out_sticky(o_st1), .out_any(o_any1), .busy(o_busy1));

    fu_alg_sticky_acc #(.LAT(2)) u_dut2 (
        .nclk(nclk), .rst_b(rst_b), .in_vld(in_vld), .in_first(in_first),
        .in_last(in_last), .in_data(in_data), .flush(flush),
        .out_vld(o_vld2), .out_sticky(o_st2), .out_any(o_any2), .busy(o_busy2));

    always #5 nclk = ~nclk;

    int n_tests = 0;
    int n_fail  = 0;
    int n       = 0;
    bit started = 0;

    bit          hv [MAXC];
    bit          hfirst [MAXC];
    bit          hlast [MAXC];
    bit          hkill [MAXC];
    logic [0:67] hd [MAXC];
    bit          eb [1:2][MAXC];

    logic [0:4] m_acc [1:2];
    bit         m_busy [1:2];
    logic [0:4] last1 = '0;
    logic [0:4] last2 = '0;
    exp_t       q1[$];
    exp_t       q2[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int q_size(input int L);
        return (L == 1) ? q1.size() : q2.size();
    endfunction

    function automatic exp_t q_front(input int L);
        return (L == 1) ? q1[0] : q2[0];
    endfunction

    task automatic q_pop(input int L, output exp_t x);
        if (L == 1) x = q1.pop_front();
        else        x = q2.pop_front();
    endtask

    task automatic q_push(input int L, input exp_t x);
        if (L == 1) q1.push_back(x);
        else        q2.push_back(x);
    endtask

    // Sticky groups straight from the bit index: bits 0..3 -> group 0, then 16 per group.
    function automatic logic [0:4] groups(input logic [0:67] d);
        logic [0:4] g;
        g = '0;
        for (int i = 0; i < 68; i++)
            if (d[i]) g[(i < 4) ? 0 : 1 + (i - 4) / 16] = 1'b1;
        return g;
    endfunction

    function automatic logic [0:67] bit1(input int i);
        logic [0:67] d;
        d = '0;
        d[i] = 1'b1;
        return d;
    endfunction

    // Beat issued at cycle b reaches the accumulator at b+L-1 unless a flush/reset
    // lands anywhere in that window.
    task automatic model_step(input int c);
        for (int L = 1; L <= 2; L++) begin
            int b;
            bit ok;
            exp_t x;
            b  = c - (L - 1);
            ok = (b >= 0) && hv[b];
            if (ok) for (int j = b; j <= c; j++) if (hkill[j]) ok = 0;
            if (hkill[c]) begin
                m_acc[L]  = '0;
                m_busy[L] = 0;
            end else if (ok) begin
                if (hfirst[b] || !m_busy[L]) m_acc[L] = groups(hd[b]);
                else                         m_acc[L] = m_acc[L] | groups(hd[b]);
                if (hlast[b]) begin
                    x.st  = m_acc[L];
                    x.tag = c;
                    q_push(L, x);
                    m_busy[L] = 0;
                end else begin
                    m_busy[L] = 1;
                end
            end
            eb[L][c] = m_busy[L];
        end
    endtask

    task automatic step(input bit v, input bit f, input bit l, input logic [0:67] d, input bit fl);
        @(negedge nclk);
        started  = 1;
        in_vld   = v;
        in_first = f;
        in_last  = l;
        in_data  = d;
        flush    = fl;
        hv[n] = v; hfirst[n] = f; hlast[n] = l; hd[n] = d; hkill[n] = fl;
        model_step(n);
        n++;
    endtask

    task automatic do_reset();
        @(negedge nclk);
        in_vld = 0; in_first = 0; in_last = 0; in_data = '0; flush = 0;
        hv[n] = 0; hfirst[n] = 0; hlast[n] = 0; hd[n] = '0; hkill[n] = 1;
        model_step(n);
        q1.delete();
        q2.delete();
        last1 = '0;
        last2 = '0;
        n++;
        cmp("busy1 before reset", 32'(o_busy1), 32'(1));
        cmp("busy2 before reset", 32'(o_busy2), 32'(1));
        #2 rst_b = 1'b0;
        #1;
        cmp("async rst out_vld1", 32'(o_vld1), 32'(0));
        cmp("async rst sticky1", 32'(o_st1), 32'(0));
        cmp("async rst any1", 32'(o_any1), 32'(0));
        cmp("async rst busy1", 32'(o_busy1), 32'(0));
        cmp("async rst out_vld2", 32'(o_vld2), 32'(0));
        cmp("async rst sticky2", 32'(o_st2), 32'(0));
        cmp("async rst any2", 32'(o_any2), 32'(0));
        cmp("async rst busy2", 32'(o_busy2), 32'(0));
        @(posedge nclk);
        #3 rst_b = 1'b1;
    endtask

    task automatic check_dut(input int L, input int e, input logic v, input logic [0:4] st,
                             input logic an, input logic bz);
        exp_t x;
        bit   pend;
        pend = (q_size(L) != 0) && (q_front(L).tag <= e);
        cmp($sformatf("dut%0d out_vld @%0d", L, e), 32'(v), 32'(pend));
        if (v && q_size(L) != 0) begin
            q_pop(L, x);
            cmp($sformatf("dut%0d latency", L), 32'(e), 32'(x.tag));
            cmp($sformatf("dut%0d out_sticky", L), 32'(st), 32'(x.st));
            cmp($sformatf("dut%0d out_any", L), 32'(an), 32'(|x.st));
            if (L == 1) last1 = x.st;
            else        last2 = x.st;
        end else if (!v && pend) begin
            q_pop(L, x);
        end else if (!v) begin
            cmp($sformatf("dut%0d held sticky", L), 32'(st), 32'((L == 1) ? last1 : last2));
        end
        cmp($sformatf("dut%0d busy @%0d", L, e), 32'(bz), 32'(eb[L][e]));
    endtask

    initial begin : monitor
        int e;
        e = 0;
        forever begin
            @(posedge nclk);
            if (started) begin
                #1;
                check_dut(1, e, o_vld1, o_st1, o_any1, o_busy1);
                check_dut(2, e, o_vld2, o_st2, o_any2, o_busy2);
                e++;
            end
        end
    end

    initial begin : stim
        logic [95:0] r;
        logic [0:67] d;
        rst_b = 1'b0;
        in_vld = 0; in_first = 0; in_last = 0; in_data = '0; flush = 0;
        for (int L = 1; L <= 2; L++) begin
            m_acc[L]  = '0;
            m_busy[L] = 0;
        end
        #1;
        cmp("reset out_vld1", 32'(o_vld1), 32'(0));
        cmp("reset sticky1", 32'(o_st1), 32'(0));
        cmp("reset busy1", 32'(o_busy1), 32'(0));
        cmp("reset out_vld2", 32'(o_vld2), 32'(0));
        cmp("reset sticky2", 32'(o_st2), 32'(0));
        cmp("reset any2", 32'(o_any2), 32'(0));
        #2 rst_b = 1'b1;

        step(1, 1, 1, bit1(3), 0);
        step(1, 1, 1, bit1(67), 0);
        step(1, 1, 1, '0, 0);
        step(0, 0, 0, '0, 0);
        step(1, 1, 0, bit1(20), 0);
        step(1, 0, 0, bit1(40), 0);
        step(1, 0, 1, bit1(0), 0);
        step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 0);
        step(1, 1, 0, bit1(5), 0);
        step(1, 0, 1, bit1(60), 1);
        step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 0);
        step(1, 1, 1, bit1(30), 0);
        step(0, 0, 0, '0, 0);
        step(1, 1, 1, bit1(10), 0);
        step(1, 1, 1, bit1(50), 0);
        step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 1);
        step(1, 1, 0, bit1(7), 0);
        step(1, 0, 0, bit1(33), 0);
        do_reset();
        step(1, 1, 1, bit1(2), 0);
        step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(3))
                0: d = '0;
                1: d = bit1($urandom_range(67));
                2: d = bit1($urandom_range(67)) | bit1($urandom_range(67));
                default: begin
                    r = {$urandom(), $urandom(), $urandom()};
                    d = r[67:0];
                end
            endcase
            step($urandom_range(9) < 7, $urandom_range(9) < 3, $urandom_range(9) < 4, d,
                 $urandom_range(19) == 0);
        end

        for (int i = 0; i < 6; i++) step(0, 0, 0, '0, 0);
        @(posedge nclk);
        #2;
        cmp("dut1 results drained", 32'(q1.size()), 32'(0));
        cmp("dut2 results drained", 32'(q2.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
